// File: rtl/alu_op_sequencer_if.sv
// Command/response channels between a requester and the ALU op sequencer.
// Command carries op plus operand; response returns captured carry/zero/error.
interface alu_op_sequencer_if #(
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_cf;
  logic              rsp_zf;
  logic              rsp_err;

  modport master (
    output cmd_valid,
    output cmd_op,
    output cmd_data,
    output rsp_ready,
    input  cmd_ready,
    input  rsp_valid,
    input  rsp_cf,
    input  rsp_zf,
    input  rsp_err
  );

  modport slave (
    input  cmd_valid,
    input  cmd_op,
    input  cmd_data,
    input  rsp_ready,
    output cmd_ready,
    output rsp_valid,
    output rsp_cf,
    output rsp_zf,
    output rsp_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Microstep controller for the 8-bit add/sub ALU, A/B registers and flags.
// Strobes decode from state and latched op only, never from the command bus.
module alu_op_sequencer #(
  parameter int ALU_SETTLE = 1,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              clr,
  alu_op_sequencer_if.slave host,
  output logic [DATA_W-1:0] dbus,
  output logic              do_en,
  output logic              ai,
  output logic              bi,
  output logic              su,
  output logic              eo,
  output logic              fi,
  input  logic              flag_c,
  input  logic              flag_z,
  output logic [2:0]        step
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    EXEC = 3'd2,
    CAPT = 3'd3,
    RESP = 3'd4
  } state_t;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_CMP = 3'd3;
  localparam logic [2:0] OP_LDA = 3'd4;
  localparam logic [2:0] OP_LDB = 3'd5;

  localparam logic [3:0] SETTLE_LD = 4'(ALU_SETTLE - 1);

  state_t     state;
  state_t     state_nx;
  logic [2:0] op_q;
  logic [3:0] cnt;
  logic       accept;
  logic       ready_st;
  logic       rsp_v;
  logic       rsp_cf;
  logic       rsp_zf;
  logic       rsp_err;

  logic op_add;
  logic op_sub;
  logic op_cmp;
  logic op_lda;
  logic op_ldb;
  logic arith;
  logic wback;
  logic in_nop;
  logic in_bad;

  assign op_add = (op_q == OP_ADD);
  assign op_sub = (op_q == OP_SUB);
  assign op_cmp = (op_q == OP_CMP);
  assign op_lda = (op_q == OP_LDA);
  assign op_ldb = (op_q == OP_LDB);
  assign arith  = op_add | op_sub | op_cmp;
  assign wback  = op_add | op_sub;

  assign in_nop = (host.cmd_op == OP_NOP);
  assign in_bad = (host.cmd_op > OP_LDB);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ready_st = 1'b0;
    accept   = 1'b0;
    rsp_v    = 1'b0;
    do_en    = 1'b0;
    ai       = 1'b0;
    bi       = 1'b0;
    su       = 1'b0;
    eo       = 1'b0;
    fi       = 1'b0;
    unique case (state)
      IDLE: begin
        ready_st = 1'b1;
        accept   = host.cmd_valid;
        if (accept) begin
          unique case (1'b1)
            in_bad:  state_nx = RESP;
            in_nop:  state_nx = CAPT;
            default: state_nx = LOAD;
          endcase
        end
      end
      LOAD: begin
        do_en = 1'b1;
        ai    = op_lda;
        bi    = arith | op_ldb;
        // subtract select goes up early so the ALU settles during LOAD
        su    = op_sub | op_cmp;
        if (op_lda | op_ldb) begin
          state_nx = CAPT;
        end else begin
          state_nx = EXEC;
        end
      end
      EXEC: begin
        su = op_sub | op_cmp;
        if (cnt == 4'd0) begin
          fi       = arith;
          eo       = wback;
          ai       = wback;
          state_nx = CAPT;
        end
      end
      CAPT: begin
        state_nx = RESP;
      end
      RESP: begin
        rsp_v = 1'b1;
        if (host.rsp_ready) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      op_q    <= OP_NOP;
      dbus    <= '0;
      cnt     <= 4'd0;
      rsp_cf  <= 1'b0;
      rsp_zf  <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      if (accept) begin
        op_q <= host.cmd_op;
        dbus <= host.cmd_data;
        if (in_bad) begin
          rsp_err <= 1'b1;
          rsp_cf  <= 1'b0;
          rsp_zf  <= 1'b0;
        end
      end
      if (state == LOAD) begin
        cnt <= SETTLE_LD;
      end else if (state == EXEC && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      // flag register has already taken the EXEC-edge update here
      if (state == CAPT) begin
        rsp_cf  <= flag_c;
        rsp_zf  <= flag_z;
        rsp_err <= 1'b0;
      end
    end
  end

  assign host.cmd_ready = ready_st & ~clr;
  assign host.rsp_valid = rsp_v;
  assign host.rsp_cf    = rsp_cf;
  assign host.rsp_zf    = rsp_zf;
  assign host.rsp_err   = rsp_err;
  assign step           = state;

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
Microstep controller that sequences the 8-bit add/subtract ALU and its flag register for one requester. It accepts a command (op plus 8-bit operand) over a valid/ready handshake and drives the datapath strobes across T-states: operand onto bus, B-register load, ALU output enable, A write-back, subtract select and flag load. It returns the resulting carry/zero flags over a valid/ready response channel. It sits between the instruction/command source and the ALU, A/B registers and flag register.

Parameters:
ALU_SETTLE, 1, number of cycles in EXEC (range 1-15); SU is held for all of them, and EO/AI/FI pulse only on the last one
DATA_W, 8, operand/bus width; fixed at 8 for this datapath

Ports:
CLK  in  1  system clock, rising edge
CLR  in  1  asynchronous active-high reset
CMD_VALID  in  1  command present
CMD_READY  out  1  sequencer can accept a command
CMD_OP  in  3  000 NOP, 001 ADD, 010 SUB, 011 CMP, 100 LDA, 101 LDB, 11x illegal
CMD_DATA  in  8  operand
DBUS  out  8  latched operand; the bus driver uses it when DO=1
DO  out  1  drive DBUS onto the shared bus
AI  out  1  load A register from bus
BI  out  1  load B register from bus
SU  out  1  ALU subtract select
EO  out  1  ALU output enable onto bus
FI  out  1  flag register load enable
FLAG_C  in  1  carry, from flag register Q
FLAG_Z  in  1  zero, from flag register Q
RSP_VALID  out  1  response present
RSP_READY  in  1  response consumed
RSP_CF  out  1  captured carry
RSP_ZF  out  1  captured zero
RSP_ERR  out  1  illegal op
STEP  out  3  state encoding for debug LEDs

Behaviour:
- States and STEP encodings: IDLE=0, LOAD=1, EXEC=2, CAPT=3, RESP=4.
- All outputs are registered or decoded from state and the latched op. No combinational path exists from CMD_* to the strobes.
- Reset values (CLR high, asynchronous): state IDLE, DBUS=0x00, all strobes 0, RSP_*=0, CMD_READY=1 once CLR is released. CLR asserted in any state immediately drops all strobes and discards the in-flight command with no response.
- IDLE: CMD_READY=1. On CMD_VALID&&CMD_READY, latch op into op_q and CMD_DATA into DBUS, then:
  - ADD/SUB/CMP/LDA/LDB go to LOAD.
  - NOP goes to CAPT.
  - Illegal ops go to RESP with RSP_ERR=1 and RSP_CF/ZF=0.
- CMD_READY=0 in every state except IDLE.
- LOAD (1 cycle): DO=1.
  - ADD/SUB/CMP: BI=1.
  - LDA: AI=1.
  - LDB: BI=1.
  - SU=1 for SUB/CMP so the ALU settles early.
  - Next state: LDA/LDB go to CAPT; the rest go to EXEC with the settle counter loaded to ALU_SETTLE-1.
- EXEC (ALU_SETTLE cycles): DO=0, SU=1 for SUB/CMP, else 0.
  - On the cycle with counter==0: FI=1 for ADD/SUB/CMP; EO=1 and AI=1 for ADD/SUB only. CMP updates flags only; A is unchanged.
  - EO/AI/FI must never be high for more than one cycle per command.
  - Counter==0 goes to CAPT; otherwise the counter decrements.
- CAPT (1 cycle): no strobes. Latch FLAG_C/FLAG_Z into RSP_CF/RSP_ZF and clear RSP_ERR. This cycle absorbs the flag-register update from the EXEC edge. For NOP/LDA/LDB it returns the current flags.
- RSP_CF/ZF/ERR are registered values and are stable throughout RESP.
- RESP: RSP_VALID=1 and holds until RSP_VALID&&RSP_READY, then the next state is IDLE. A new command cannot be accepted in the same cycle as the response handshake.
- Latency (ALU_SETTLE=1), counted from the accept edge:
  - ADD/SUB/CMP: RSP_VALID rises after 4 edges. Minimum issue interval is 5 cycles.
  - LDA/LDB: 3 edges.
  - NOP: 2 edges.
  - Illegal: 1 edge.
- Flag arithmetic is the ALU's own: SUB/CMP is A+~B+1, so CF=1 means no borrow (A>=B).

Test Plan:
- LDA 0x05, then ADD 0x03, with the bench modelling the A/B registers, ALU and flag register -> A=0x08; RSP_CF=0, RSP_ZF=0; exactly one EO/AI/FI pulse; SU=0 throughout.
- A=0x08, SUB 0x08 -> A=0x00, RSP_CF=1, RSP_ZF=1; SU high across LOAD and EXEC; RSP_VALID 4 edges after accept.
- A=0x03, CMP 0x05 -> A stays 0x03, EO/AI never high, FI pulses once; RSP_CF=0, RSP_ZF=0.
- CMD_OP=3'b111 -> no strobes; RSP_VALID after 1 edge with RSP_ERR=1; next ADD returns RSP_ERR=0.
- ALU_SETTLE=3 with ADD 0x01 and RSP_READY held low for 5 cycles -> EXEC lasts 3 cycles with the strobes only in the last; RSP fields stable while stalled; CMD_READY stays 0 until the cycle after the handshake.
- CLR pulsed mid-EXEC (first cycle, ALU_SETTLE=3) -> strobes drop asynchronously, STEP=0, no response issued; a following LDA 0x7F completes normally.
